// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// Host-side SPI transaction sequencer for the SPI-slave/RAM wrapper.
// A single host request (write or read) becomes one or two 10-bit command
// frames: {cmd[1:0], payload[7:0]}, sent MSB first on MOSI while SS_n is low.
//   00 = write address, 01 = write data, 10 = read address, 11 = read data.
// A read-data frame is followed by a MISO latency window and an 8-bit capture.
//
// Optional feature: define SPI_CTRL_ADDR_CACHE_EN to remember the last write
// and read addresses and skip the address frame when it would be redundant.
// With the macro undefined every transaction sends both frames and no cache
// registers exist.
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int unsigned PRE_CYC  = 2,  // SS_n-low cycles before the first frame bit
    parameter int unsigned MISO_LAT = 2,  // cycles between last MOSI bit and first MISO sample
    parameter int unsigned GAP_CYC  = 1   // minimum SS_n-high cycles between frames
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_RD_WAIT,
        S_RD_CAP,
        S_GAP,
        S_DONE
    } state_t;

    // Terminal counts of the per-state cycle counter (counter restarts at 0
    // on every state entry, so "last" is length-1).
    localparam logic [3:0] PRE_LAST = 4'(PRE_CYC - 1);
    localparam logic [3:0] LAT_LAST = 4'(MISO_LAT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);
    localparam logic [3:0] BIT_LAST = 4'd9;
    localparam logic [3:0] CAP_LAST = 4'd7;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;          // cycles spent in the current state
    logic        op_rd_q, op_rd_d;      // latched operation: 1 = read
    logic [7:0]  addr_q, addr_d;        // latched RAM address
    logic [7:0]  wdata_q, wdata_d;      // latched write data (0 for reads)
    logic        frame_sel_q, frame_sel_d;  // 0 = address frame, 1 = data frame
    logic [7:0]  shift_q, shift_d;      // MISO capture shift register
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        skip_first;            // start directly with the data frame
    logic [3:0]  cnt_inc;
    logic [9:0]  cur_frame;

    assign accept = req_valid && (state_q == S_IDLE);

    // Saturating increment: the counter never wraps even if a terminal count
    // were missed.
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    // The frame on the wire is fully determined by the latched request and
    // which of the two frames is in flight. The data frame is always the last.
    assign cur_frame = {op_rd_q, frame_sel_q,
                        frame_sel_q ? (op_rd_q ? 8'h00 : wdata_q) : addr_q};

`ifdef SPI_CTRL_ADDR_CACHE_EN
    logic        wr_vld_q, wr_vld_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic        rd_vld_q, rd_vld_d;
    logic [7:0]  rd_addr_q, rd_addr_d;

    // Address frame is redundant when the slave already holds this address
    // for the same direction.
    assign skip_first = req_wr ? (wr_vld_q && (req_addr == wr_addr_q))
                               : (rd_vld_q && (req_addr == rd_addr_q));

    // Track the last address sent per direction; a write to the cached read
    // address invalidates the read entry.
    always_comb begin
        wr_vld_d  = wr_vld_q;
        wr_addr_d = wr_addr_q;
        rd_vld_d  = rd_vld_q;
        rd_addr_d = rd_addr_q;
        if (accept) begin
            if (req_wr) begin
                wr_vld_d  = 1'b1;
                wr_addr_d = req_addr;
                if (req_addr == rd_addr_q) begin
                    rd_vld_d = 1'b0;
                end
            end else begin
                rd_vld_d  = 1'b1;
                rd_addr_d = req_addr;
            end
        end
    end

    // Address cache registers, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_q  <= 1'b0;
            wr_addr_q <= 8'h00;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= 8'h00;
        end else begin
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            rd_vld_q  <= rd_vld_d;
            rd_addr_q <= rd_addr_d;
        end
    end
`else
    assign skip_first = 1'b0;
`endif

    // Next-state and datapath update for the transaction sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case statement so no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_inc;
        op_rd_d     = op_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        frame_sel_d = frame_sel_q;
        shift_d     = shift_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (accept) begin
                    op_rd_d     = !req_wr;
                    addr_d      = req_addr;
                    wdata_d     = req_wr ? req_wdata : 8'h00;
                    frame_sel_d = skip_first;
                    state_d     = S_PRE;
                end
            end

            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 4'd0;
                    if (frame_sel_q && op_rd_q) begin
                        state_d = S_RD_WAIT;
                    end else if (frame_sel_q) begin
                        // Write complete: DONE also serves as the SS_n-high gap.
                        rsp_rdata_d = 8'h00;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end

            S_RD_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_RD_CAP;
                end
            end

            S_RD_CAP: begin
                // MISO is only ever looked at here, so an undriven line
                // elsewhere cannot reach any register.
                shift_d = {shift_q[6:0], MISO};
                if (cnt_q == CAP_LAST) begin
                    cnt_d       = 4'd0;
                    rsp_rdata_d = {shift_q[6:0], MISO};
                    state_d     = S_DONE;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d       = 4'd0;
                    frame_sel_d = 1'b1;
                    state_d     = S_PRE;
                end
            end

            S_DONE: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end

            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            op_rd_q     <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            frame_sel_q <= 1'b0;
            shift_q     <= 8'h00;
            rsp_rdata_q <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_rd_q     <= op_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            frame_sel_q <= frame_sel_d;
            shift_q     <= shift_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Moore outputs decoded from the state register, so an asynchronous reset
    // raises SS_n and drops rsp_valid immediately.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        SS_n      = 1'b1;
        MOSI      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_PRE: begin
                SS_n = 1'b0;
                MOSI = cur_frame[9];
            end
            S_SHIFT: begin
                SS_n = 1'b0;
                MOSI = cur_frame[BIT_LAST - cnt_q];
            end
            S_RD_WAIT, S_RD_CAP: begin
                SS_n = 1'b0;
            end
            S_GAP: begin
                SS_n = 1'b1;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Directed plus randomized bench for spi_master_ctrl. A reference model turns
// each request into its frame list and an expected cycle-by-cycle timeline
// (SS_n, MOSI, rsp_valid, MISO capture slots); the bench plays the slave by
// driving MISO only in the capture slots and noise elsewhere.
// Honors SPI_CTRL_ADDR_CACHE_EN in the model when the design is built with it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_ctrl;

    localparam int PRE_CYC  = 2;
    localparam int MISO_LAT = 2;
    localparam int GAP_CYC  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_wr = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       MISO = 1'b0;
    logic       req_ready, rsp_valid, busy, SS_n, MOSI;
    logic [7:0] rsp_rdata;

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .PRE_CYC (PRE_CYC),
        .MISO_LAT(MISO_LAT),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef logic [9:0] frame_t;
    typedef struct {
        bit ss;        // expected SS_n
        bit mosi_chk;  // MOSI is defined in this cycle
        bit mosi;      // expected MOSI
        bit rv;        // expected rsp_valid
        int cap;       // MISO capture slot 0..7, or -1
    } step_t;

    frame_t frames[$];
    step_t  tl[$];

    bit         m_wr_v = 1'b0;
    bit         m_rd_v = 1'b0;
    logic [7:0] m_wr_a = 8'h00;
    logic [7:0] m_rd_a = 8'h00;

    int         last_lat;
    logic [7:0] last_rdata;

    function automatic void push_step(bit ss, bit mc, bit m, bit rv, int cap);
        step_t s;
        s.ss = ss; s.mosi_chk = mc; s.mosi = m; s.rv = rv; s.cap = cap;
        tl.push_back(s);
    endfunction

    function automatic void model_reset();
        m_wr_v = 1'b0;
        m_rd_v = 1'b0;
    endfunction

    // Frame list and expected timeline for one accepted request; cycle 1 is
    // the cycle after acceptance.
    function automatic void model_accept(bit wr, logic [7:0] a, logic [7:0] d);
        bit skip;
        frame_t f;
        skip = 1'b0;
        frames.delete();
        tl.delete();
`ifdef SPI_CTRL_ADDR_CACHE_EN
        if (wr) begin
            skip   = m_wr_v && (m_wr_a == a);
            m_wr_v = 1'b1;
            m_wr_a = a;
            if (m_rd_a == a) m_rd_v = 1'b0;
        end else begin
            skip   = m_rd_v && (m_rd_a == a);
            m_rd_v = 1'b1;
            m_rd_a = a;
        end
`endif
        if (!skip) frames.push_back(wr ? {2'b00, a} : {2'b10, a});
        frames.push_back(wr ? {2'b01, d} : {2'b11, 8'h00});
        for (int i = 0; i < frames.size(); i++) begin
            f = frames[i];
            for (int p = 0; p < PRE_CYC; p++) push_step(1'b0, 1'b1, f[9], 1'b0, -1);
            for (int b = 9; b >= 0; b--) push_step(1'b0, 1'b1, f[b], 1'b0, -1);
            if (f[9:8] == 2'b11) begin
                for (int w = 0; w < MISO_LAT; w++) push_step(1'b0, 1'b1, 1'b0, 1'b0, -1);
                for (int c = 0; c < 8; c++) push_step(1'b0, 1'b0, 1'b0, 1'b0, c);
            end
            if (i != frames.size() - 1)
                for (int g = 0; g < GAP_CYC; g++) push_step(1'b1, 1'b0, 1'b0, 1'b0, -1);
        end
        push_step(1'b1, 1'b0, 1'b0, 1'b1, -1);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_req(input bit wr, input logic [7:0] a, input logic [7:0] d);
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
    endtask

    // Called at a negedge while a request is presented to an idle DUT.
    // Returns at the negedge of the idle cycle after rsp_valid; with hold_next
    // the next request is already presented there.
    task automatic run_txn(input string name, input logic [7:0] miso_byte, input bit x_miso,
                           input bit hold_next, input bit nwr, input logic [7:0] naddr,
                           input logic [7:0] nwdata);
        logic [7:0] exp_rd;
        step_t s;
        int n;
        check({name, "_accept_ready"}, req_ready, 1);
        exp_rd = req_wr ? 8'h00 : miso_byte;
        model_accept(req_wr, req_addr, req_wdata);
        n = tl.size();
        last_lat   = 0;
        last_rdata = 8'h00;
        @(posedge clk);
        @(negedge clk);
        if (hold_next) begin
            req_wr    = nwr;
            req_addr  = naddr;
            req_wdata = nwdata;
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 1; k <= n; k++) begin
            s = tl[k-1];
            check($sformatf("%s_ss_c%0d", name, k), SS_n, s.ss);
            if (s.mosi_chk) check($sformatf("%s_mosi_c%0d", name, k), MOSI, s.mosi);
            check($sformatf("%s_rv_c%0d", name, k), rsp_valid, s.rv);
            check($sformatf("%s_busy_c%0d", name, k), busy, 1);
            check($sformatf("%s_ready_c%0d", name, k), req_ready, 0);
            if (rsp_valid === 1'b1 && last_lat == 0) begin
                last_lat   = k;
                last_rdata = rsp_rdata;
            end
            if (s.rv) check($sformatf("%s_rdata", name), rsp_rdata, exp_rd);
            if (s.cap >= 0)      MISO = miso_byte[7 - s.cap];
            else if (x_miso)     MISO = 1'bx;
            else                 MISO = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check({name, "_latency"}, last_lat, n);
        check({name, "_idle_ss"}, SS_n, 1);
        check({name, "_idle_rv"}, rsp_valid, 0);
        check({name, "_idle_ready"}, req_ready, 1);
        check({name, "_idle_busy"}, busy, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit         pending;
        bit         rwr, nwr, hold;
        logic [7:0] raddr, rwd, rmiso, naddr, nwd;
        int         rv_seen, ss_low_seen;

        // Reset values
        @(negedge clk);
        check("rst_ss", SS_n, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_ready", req_ready, 1);
        check("rst_rv", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        // T1: asynchronous reset in the middle of a write frame
        start_req(1'b1, 8'h3C, 8'hA5);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_mid_ss", SS_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_ss", SS_n, 1);
        check("t1_async_rv", rsp_valid, 0);
        check("t1_async_ready", req_ready, 1);
        check("t1_async_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        ss_low_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) rv_seen++;
            if (SS_n !== 1'b1) ss_low_seen++;
        end
        check("t1_no_rsp", rv_seen, 0);
        check("t1_no_frame", ss_low_seen, 0);

        // T2: write 3C <- A5
        start_req(1'b1, 8'h3C, 8'hA5);
        run_txn("t2", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t2_lat26", last_lat, 26);

        // T3: read 3C, slave returns A5
        start_req(1'b0, 8'h3C, 8'h00);
        run_txn("t3", 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t3_lat36", last_lat, 36);
        check("t3_rdata_a5", last_rdata, 8'hA5);

        // T4: second request held high while busy
        start_req(1'b1, 8'h55, 8'h66);
        run_txn("t4a", 8'h00, 1'b0, 1'b1, 1'b0, 8'h55, 8'h00);
        run_txn("t4b", 8'h66, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t4b_rdata", last_rdata, 8'h66);

        // T5: repeated addresses (cache behaviour when enabled)
        start_req(1'b1, 8'h10, 8'h01);
        run_txn("t5w1", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        start_req(1'b1, 8'h10, 8'h02);
        run_txn("t5w2", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef SPI_CTRL_ADDR_CACHE_EN
        check("t5w2_lat13", last_lat, 13);
`else
        check("t5w2_lat26", last_lat, 26);
`endif
        start_req(1'b0, 8'h10, 8'h00);
        run_txn("t5r1", 8'h3E, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t5r1_lat36", last_lat, 36);
        start_req(1'b1, 8'h10, 8'h03);
        run_txn("t5w3", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        start_req(1'b0, 8'h10, 8'h00);
        run_txn("t5r2", 8'hC1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t5r2_lat36", last_lat, 36);

        // T6: undriven MISO outside capture, alternating bits inside
        start_req(1'b0, 8'h77, 8'h00);
        run_txn("t6", 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t6_rdata_aa", last_rdata, 8'hAA);
        check("t6_mosi_known", MOSI, 0);

        // Randomized transactions, optionally back-to-back
        pending = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!pending) begin
                rwr   = 1'($urandom_range(0, 1));
                raddr = ($urandom_range(0, 1) == 1) ? 8'h10 : 8'($urandom);
                rwd   = 8'($urandom);
                start_req(rwr, raddr, rwd);
            end
            rmiso = 8'($urandom);
            nwr   = 1'($urandom_range(0, 1));
            naddr = ($urandom_range(0, 1) == 1) ? 8'h10 : 8'($urandom);
            nwd   = 8'($urandom);
            hold  = (i < 11) && ($urandom_range(0, 1) == 1);
            run_txn($sformatf("rnd%0d", i), rmiso, 1'b0, hold, nwr, naddr, nwd);
            pending = hold;
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
